algo_nr1w_dup_fwd: RTL and testbench

ALGO_NR1W_DUP_FWD -- requirements
Module: algo_nr1w_dup_fwd

---
 rtl/algo_dup_pkg.sv | 19 +
 rtl/dup_rd_fwd_pipe.sv | 80 ++++++++
 rtl/algo_nr1w_dup_fwd.sv | 150 +++++++++++++++
 tb/tb_algo_nr1w_dup_fwd.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_dup_pkg.sv
// Shared FSM state type and address-split helpers for the duplicated-bank nR1W memory.
package algo_dup_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } dup_state_e;

  // Low address bits select the bank inside one copy.
  function automatic int unsigned adr_bank(input int unsigned adr, input int unsigned bitvbnk);
    return adr & ((32'd1 << bitvbnk) - 32'd1);
  endfunction

  function automatic int unsigned adr_row(input int unsigned adr, input int unsigned bitvbnk);
    return adr >> bitvbnk;
  endfunction

endpackage

// File: rtl/dup_rd_fwd_pipe.sv
// Per-read-port pipeline: carries valid, bank and same-cycle write-forward data
// alongside the SRAM access, then merges forwarded bits over the SRAM word.
module dup_rd_fwd_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUMVBNK    = 8,
  parameter int unsigned BITVBNK    = 3,
  parameter int unsigned SRAM_DELAY = 2,
  parameter int unsigned FLOPOUT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic [BITVBNK-1:0]         i_bank,
  input  logic [WIDTH-1:0]           i_fwd_bw,
  input  logic [WIDTH-1:0]           i_fwd_din,
  input  logic [NUMVBNK*WIDTH-1:0]   i_doutB,
  output logic                       o_vld,
  output logic [WIDTH-1:0]           o_dout
);

  localparam int unsigned LAST = SRAM_DELAY - 1;

  logic [SRAM_DELAY-1:0] r_vld;
  logic [BITVBNK-1:0]    r_bank [SRAM_DELAY];
  logic [WIDTH-1:0]      r_bw   [SRAM_DELAY];
  logic [WIDTH-1:0]      r_din  [SRAM_DELAY];
  logic [WIDTH-1:0]      w_sram;
  logic [WIDTH-1:0]      w_merge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < SRAM_DELAY; i++) begin
        r_bank[i] <= '0;
        r_bw[i]   <= '0;
        r_din[i]  <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld;
      r_bank[0] <= i_bank;
      r_bw[0]   <= i_fwd_bw;
      r_din[0]  <= i_fwd_din;
      for (int unsigned i = 1; i < SRAM_DELAY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_bank[i] <= r_bank[i-1];
        r_bw[i]   <= r_bw[i-1];
        r_din[i]  <= r_din[i-1];
      end
    end
  end

  // Select the returning bank and overlay any bits written in the read cycle.
  always_comb begin
    w_sram = '0;
    for (int unsigned b = 0; b < NUMVBNK; b++) begin
      if (r_bank[LAST] == BITVBNK'(b)) w_sram = i_doutB[b*WIDTH +: WIDTH];
    end
    w_merge = r_vld[LAST] ? ((w_sram & ~r_bw[LAST]) | (r_din[LAST] & r_bw[LAST])) : '0;
  end

  if (FLOPOUT != 0) begin : g_flop
    logic             r_ovld;
    logic [WIDTH-1:0] r_odout;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ovld  <= 1'b0;
        r_odout <= '0;
      end else begin
        r_ovld  <= r_vld[LAST];
        r_odout <= w_merge;
      end
    end
    assign o_vld  = r_ovld;
    assign o_dout = r_odout;
  end else begin : g_noflop
    assign o_vld  = r_vld[LAST];
    assign o_dout = w_merge;
  end

endmodule

// File: rtl/algo_nr1w_dup_fwd.sv
// N-read/1-write memory built from NUMRDPT duplicated bank copies; writes go to every
// copy, each read port owns one copy, same-cycle write/read collisions are forwarded.
module algo_nr1w_dup_fwd
  import algo_dup_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUMRDPT    = 4,
  parameter int unsigned NUMADDR    = 8192,
  parameter int unsigned BITADDR    = 13,
  parameter int unsigned NUMVBNK    = 8,
  parameter int unsigned BITVBNK    = 3,
  parameter int unsigned NUMVROW    = 1024,
  parameter int unsigned BITVROW    = 10,
  parameter int unsigned SRAM_DELAY = 2,
  parameter int unsigned FLOPOUT    = 0,
  parameter int unsigned INITENA    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  ready,
  input  logic                                  write,
  input  logic [BITADDR-1:0]                    wr_adr,
  input  logic [WIDTH-1:0]                      bw,
  input  logic [WIDTH-1:0]                      din,
  input  logic [NUMRDPT-1:0]                    read,
  input  logic [NUMRDPT*BITADDR-1:0]            rd_adr,
  output logic [NUMRDPT-1:0]                    rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]              rd_dout,
  output logic [NUMRDPT*NUMVBNK-1:0]            t1_writeA,
  output logic [NUMRDPT*NUMVBNK*BITVROW-1:0]    t1_addrA,
  output logic [NUMRDPT*NUMVBNK*WIDTH-1:0]      t1_bwA,
  output logic [NUMRDPT*NUMVBNK*WIDTH-1:0]      t1_dinA,
  output logic [NUMRDPT*NUMVBNK-1:0]            t1_readB,
  output logic [NUMRDPT*NUMVBNK*BITVROW-1:0]    t1_addrB,
  input  logic [NUMRDPT*NUMVBNK*WIDTH-1:0]      t1_doutB
);

  dup_state_e         r_state;
  logic [BITVROW-1:0] r_row_cnt;
  logic               r_ready;
  logic               w_init;
  logic               w_wr_acc;
  logic [BITVBNK-1:0] w_wr_bank;
  logic [BITVROW-1:0] w_wr_row;

  // Bring-up sequencer: one RESET cycle, optional zero-fill, then READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_row_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_row_cnt <= '0;
          if (INITENA != 0) begin
            r_state <= ST_INIT;
          end else begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_INIT: begin
          if (r_row_cnt == BITVROW'(NUMVROW - 1)) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_row_cnt <= r_row_cnt + BITVROW'(1);
          end
        end
        ST_READY: r_ready <= 1'b1;
        default: begin
          r_state <= ST_RESET;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign w_init    = (r_state == ST_INIT);
  assign w_wr_acc  = r_ready && write && (32'(wr_adr) < NUMADDR);
  assign w_wr_bank = BITVBNK'(adr_bank(32'(wr_adr), BITVBNK));
  assign w_wr_row  = BITVROW'(adr_row(32'(wr_adr), BITVBNK));

  // Write side: zero-fill rows during INIT, otherwise broadcast to every copy.
  always_comb begin
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_bwA    = '0;
    t1_dinA   = '0;
    for (int unsigned c = 0; c < NUMRDPT; c++) begin
      for (int unsigned b = 0; b < NUMVBNK; b++) begin
        if (w_init) begin
          t1_writeA[c*NUMVBNK + b]                        = 1'b1;
          t1_addrA[(c*NUMVBNK + b)*BITVROW +: BITVROW]    = r_row_cnt;
          t1_bwA[(c*NUMVBNK + b)*WIDTH +: WIDTH]          = '1;
        end else if (w_wr_acc && (w_wr_bank == BITVBNK'(b))) begin
          t1_writeA[c*NUMVBNK + b]                        = 1'b1;
          t1_addrA[(c*NUMVBNK + b)*BITVROW +: BITVROW]    = w_wr_row;
          t1_bwA[(c*NUMVBNK + b)*WIDTH +: WIDTH]          = bw;
          t1_dinA[(c*NUMVBNK + b)*WIDTH +: WIDTH]         = din;
        end
      end
    end
  end

  for (genvar p = 0; p < NUMRDPT; p++) begin : g_rd
    logic [BITADDR-1:0] w_adr;
    logic               w_acc;
    logic               w_hit;
    logic [BITVBNK-1:0] w_bank;
    logic [BITVROW-1:0] w_row;
    logic [WIDTH-1:0]   w_fwd_bw;
    logic [WIDTH-1:0]   w_fwd_din;

    assign w_adr     = rd_adr[p*BITADDR +: BITADDR];
    assign w_acc     = r_ready && read[p] && (32'(w_adr) < NUMADDR);
    assign w_hit     = w_acc && w_wr_acc && (w_adr == wr_adr);
    assign w_bank    = BITVBNK'(adr_bank(32'(w_adr), BITVBNK));
    assign w_row     = BITVROW'(adr_row(32'(w_adr), BITVBNK));
    assign w_fwd_bw  = w_hit ? bw : '0;
    assign w_fwd_din = w_hit ? din : '0;

    // Each port reads only its own copy.
    for (genvar b = 0; b < NUMVBNK; b++) begin : g_bnk
      assign t1_readB[p*NUMVBNK + b]                     = w_acc && (w_bank == BITVBNK'(b));
      assign t1_addrB[(p*NUMVBNK + b)*BITVROW +: BITVROW] = w_row;
    end

    dup_rd_fwd_pipe #(
      .WIDTH      (WIDTH),
      .NUMVBNK    (NUMVBNK),
      .BITVBNK    (BITVBNK),
      .SRAM_DELAY (SRAM_DELAY),
      .FLOPOUT    (FLOPOUT)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .i_vld     (w_acc),
      .i_bank    (w_bank),
      .i_fwd_bw  (w_fwd_bw),
      .i_fwd_din (w_fwd_din),
      .i_doutB   (t1_doutB[p*NUMVBNK*WIDTH +: NUMVBNK*WIDTH]),
      .o_vld     (rd_vld[p]),
      .o_dout    (rd_dout[p*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_algo_nr1w_dup_fwd.sv
// Bench for algo_nr1w_dup_fwd: two instances (2-cycle comb-out, 3-cycle + flop-out)
// share stimulus; each has a behavioural SRAM and a logical-memory reference.
`timescale 1ns/1ps
module tb_algo_nr1w_dup_fwd;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUMRDPT = 4;
  localparam int unsigned BITADDR = 13;
  localparam int unsigned NUMVBNK = 8;
  localparam int unsigned BITVBNK = 3;
  localparam int unsigned NUMVROW = 1024;
  localparam int unsigned BITVROW = 10;
  localparam int unsigned NSLC    = NUMRDPT * NUMVBNK;
  localparam int unsigned NINST   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                         write;
  logic [BITADDR-1:0]           wr_adr;
  logic [WIDTH-1:0]             bw, din;
  logic [NUMRDPT-1:0]           read;
  logic [NUMRDPT*BITADDR-1:0]   rd_adr;

  logic                         ready_a     [NINST];
  logic [NUMRDPT-1:0]           rd_vld_a    [NINST];
  logic [NUMRDPT*WIDTH-1:0]     rd_dout_a   [NINST];
  logic [NSLC-1:0]              t1_writeA_a [NINST];
  logic [NSLC-1:0]              t1_readB_a  [NINST];
  logic [NSLC*BITVROW-1:0]      t1_addrA_a  [NINST];
  logic [NSLC*BITVROW-1:0]      t1_addrB_a  [NINST];
  logic [NSLC*WIDTH-1:0]        t1_bwA_a    [NINST];
  logic [NSLC*WIDTH-1:0]        t1_dinA_a   [NINST];

  always #5 clk = ~clk;

  function automatic int unsigned lat_of(input int g);
    return (g == 0) ? 2 : 4;
  endfunction

  function automatic int unsigned na_of(input int g);
    return (g == 0) ? 8192 : 8000;
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int unsigned SD = (g == 0) ? 2 : 3;
    localparam int unsigned FO = (g == 0) ? 0 : 1;
    localparam int unsigned NA = (g == 0) ? 8192 : 8000;

    logic [NSLC*WIDTH-1:0] doutB;
    logic [WIDTH-1:0]      mem  [NSLC*NUMVROW];
    logic [WIDTH-1:0]      pipe [NSLC][SD];
    bit                    filled = 1'b0;

    algo_nr1w_dup_fwd #(
      .WIDTH(WIDTH), .NUMRDPT(NUMRDPT), .NUMADDR(NA), .BITADDR(BITADDR),
      .NUMVBNK(NUMVBNK), .BITVBNK(BITVBNK), .NUMVROW(NUMVROW), .BITVROW(BITVROW),
      .SRAM_DELAY(SD), .FLOPOUT(FO), .INITENA(1)
    ) u_dut (
      .clk(clk), .rst(rst), .ready(ready_a[g]),
      .write(write), .wr_adr(wr_adr), .bw(bw), .din(din),
      .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld_a[g]), .rd_dout(rd_dout_a[g]),
      .t1_writeA(t1_writeA_a[g]), .t1_addrA(t1_addrA_a[g]), .t1_bwA(t1_bwA_a[g]),
      .t1_dinA(t1_dinA_a[g]), .t1_readB(t1_readB_a[g]), .t1_addrB(t1_addrB_a[g]),
      .t1_doutB(doutB)
    );

    // SRAM model: read-before-write, data returns SD cycles after the read; stale garbage before INIT.
    always @(posedge clk) begin
      if (!filled) begin
        for (int i = 0; i < int'(NSLC*NUMVROW); i++) mem[i] <= WIDTH'(32'h5A00_0000 + i);
        filled <= 1'b1;
      end
      for (int s = 0; s < int'(NSLC); s++) begin
        for (int d = int'(SD) - 1; d > 0; d--) pipe[s][d] <= pipe[s][d-1];
        pipe[s][0] <= t1_readB_a[g][s] ?
                      mem[s*NUMVROW + int'(t1_addrB_a[g][s*BITVROW +: BITVROW])] : 32'hBAD0_BAD0;
        if (t1_writeA_a[g][s]) begin
          mem[s*NUMVROW + int'(t1_addrA_a[g][s*BITVROW +: BITVROW])] <=
            (mem[s*NUMVROW + int'(t1_addrA_a[g][s*BITVROW +: BITVROW])] & ~t1_bwA_a[g][s*WIDTH +: WIDTH]) |
            (t1_dinA_a[g][s*WIDTH +: WIDTH] & t1_bwA_a[g][s*WIDTH +: WIDTH]);
        end
      end
    end

    always_comb begin
      doutB = '0;
      for (int s = 0; s < int'(NSLC); s++) doutB[s*WIDTH +: WIDTH] = pipe[s][SD-1];
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int          n_post = 0;
  int unsigned cyc = 0;
  logic [WIDTH-1:0]   ref_mem [NINST][8192];
  logic [NUMRDPT-1:0] h_vld   [NINST][8];
  logic [WIDTH-1:0]   h_dat   [NINST][8][NUMRDPT];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference for one cycle: expected outputs, then apply this cycle's accepted requests.
  task automatic model_cycle();
    logic rdy, init_ph, acc_w;
    logic [NSLC-1:0] exp_wa, exp_rb;
    logic [NUMRDPT-1:0] cur_vld;
    logic [WIDTH-1:0] cur_dat [NUMRDPT];
    int unsigned a, s, e;
    for (int g = 0; g < int'(NINST); g++) begin
      rdy     = !rst && (n_post >= int'(NUMVROW) + 1);
      init_ph = !rst && (n_post >= 1) && (n_post <= int'(NUMVROW));
      chk($sformatf("ready%0d", g), 64'(ready_a[g]), 64'(rdy));
      acc_w = rdy && write && (int'(wr_adr) < int'(na_of(g)));
      exp_wa = '0;
      if (init_ph) exp_wa = '1;
      else if (acc_w) for (int c = 0; c < int'(NUMRDPT); c++) exp_wa[c*NUMVBNK + wr_adr % NUMVBNK] = 1'b1;
      chk($sformatf("writeA%0d", g), 64'(t1_writeA_a[g]), 64'(exp_wa));
      if (init_ph) begin
        chk($sformatf("init_row%0d", g), 64'(t1_addrA_a[g][BITVROW-1:0]), 64'(n_post - 1));
        chk($sformatf("init_bw%0d", g), 64'(t1_bwA_a[g][WIDTH-1:0]), 64'(32'hFFFF_FFFF));
        chk($sformatf("init_din%0d", g), 64'(t1_dinA_a[g][WIDTH-1:0]), 64'd0);
      end else if (acc_w) begin
        s = (NUMRDPT - 1) * NUMVBNK + wr_adr % NUMVBNK;
        chk($sformatf("wr_row%0d", g), 64'(t1_addrA_a[g][s*BITVROW +: BITVROW]), 64'(wr_adr / NUMVBNK));
        chk($sformatf("wr_bw%0d", g), 64'(t1_bwA_a[g][s*WIDTH +: WIDTH]), 64'(bw));
        chk($sformatf("wr_din%0d", g), 64'(t1_dinA_a[g][s*WIDTH +: WIDTH]), 64'(din));
      end
      if (rst) for (int i = 0; i < 8192; i++) ref_mem[g][i] = '0;
      if (acc_w) ref_mem[g][wr_adr] = (ref_mem[g][wr_adr] & ~bw) | (din & bw);
      exp_rb  = '0;
      cur_vld = '0;
      for (int p = 0; p < int'(NUMRDPT); p++) begin
        a = int'(rd_adr[p*BITADDR +: BITADDR]);
        cur_dat[p] = '0;
        if (rdy && read[p] && a < na_of(g)) begin
          s = p * NUMVBNK + a % NUMVBNK;
          exp_rb[s]  = 1'b1;
          cur_vld[p] = 1'b1;
          cur_dat[p] = ref_mem[g][a];
          chk($sformatf("rd_row%0d_%0d", g, p), 64'(t1_addrB_a[g][s*BITVROW +: BITVROW]), 64'(a / NUMVBNK));
        end
      end
      chk($sformatf("readB%0d", g), 64'(t1_readB_a[g]), 64'(exp_rb));
      if (rst) for (int k = 0; k < 8; k++) h_vld[g][k] = '0;
      e = (cyc - lat_of(g)) % 8;
      chk($sformatf("rd_vld%0d", g), 64'(rd_vld_a[g]), 64'(h_vld[g][e]));
      for (int p = 0; p < int'(NUMRDPT); p++)
        chk($sformatf("rd_dout%0d_%0d", g, p), 64'(rd_dout_a[g][p*WIDTH +: WIDTH]),
            64'(h_vld[g][e][p] ? h_dat[g][e][p] : '0));
      h_vld[g][cyc % 8] = cur_vld;
      for (int p = 0; p < int'(NUMRDPT); p++) h_dat[g][cyc % 8][p] = cur_dat[p];
    end
    cyc++;
    if (rst) n_post = 0;
    else if (n_post < 100000) n_post++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; wr_adr = '0; bw = '0; din = '0; read = '0; rd_adr = '0;
  endtask

  function automatic logic [BITADDR-1:0] rnd_adr();
    case ($urandom_range(0, 2))
      0:       return BITADDR'($urandom_range(0, 15));
      1:       return BITADDR'($urandom);
      default: return BITADDR'($urandom_range(7990, 8191));
    endcase
  endfunction

  task automatic rnd_stim();
    write  = 1'($urandom_range(0, 1));
    wr_adr = rnd_adr();
    din    = $urandom;
    case ($urandom_range(0, 2))
      0:       bw = '1;
      1:       bw = $urandom;
      default: bw = 32'h0000_FFFF;
    endcase
    for (int p = 0; p < int'(NUMRDPT); p++) begin
      read[p] = 1'($urandom_range(0, 1));
      rd_adr[p*BITADDR +: BITADDR] = rnd_adr();
    end
  endtask

  task automatic rd_all(input logic [BITADDR-1:0] a);
    read = '1;
    for (int p = 0; p < int'(NUMRDPT); p++) rd_adr[p*BITADDR +: BITADDR] = a;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    // Requests during RESET/INIT must be ignored.
    for (int i = 0; i < int'(NUMVROW) + 1; i++) begin rnd_stim(); step(); end

    idle(); rd_all(13'd5); step(); idle(); step();
    chk("init_rd_vld", 64'(rd_vld_a[0]), 64'h0F);
    chk("init_rd_dout", 64'(rd_dout_a[0][WIDTH-1:0]), 64'd0);

    idle(); write = 1'b1; wr_adr = 13'd9; bw = '1; din = 32'hDEAD_BEEF; step();
    idle(); rd_all(13'd9); step(); idle(); step();
    chk("rw_vld", 64'(rd_vld_a[0]), 64'h0F);
    for (int p = 0; p < int'(NUMRDPT); p++)
      chk($sformatf("rw_dout_p%0d", p), 64'(rd_dout_a[0][p*WIDTH +: WIDTH]), 64'(32'hDEAD_BEEF));
    step(); step();
    chk("rw_vld_flop", 64'(rd_vld_a[1]), 64'h0F);
    chk("rw_dout_flop", 64'(rd_dout_a[1][3*WIDTH +: WIDTH]), 64'(32'hDEAD_BEEF));

    idle(); write = 1'b1; wr_adr = 13'd9; bw = 32'h0000_FFFF; din = 32'h1234_5678;
    read[2] = 1'b1; rd_adr[2*BITADDR +: BITADDR] = 13'd9; step(); idle(); step();
    chk("fwd_dout", 64'(rd_dout_a[0][2*WIDTH +: WIDTH]), 64'(32'hDEAD_5678));
    step(); step();
    chk("fwd_dout_flop", 64'(rd_dout_a[1][2*WIDTH +: WIDTH]), 64'(32'hDEAD_5678));

    idle(); read[1] = 1'b1; rd_adr[1*BITADDR +: BITADDR] = 13'd8100; #1;
    chk("oor_readB", 64'(t1_readB_a[1]), 64'd0);
    chk("inr_readB", 64'(t1_readB_a[0][1*NUMVBNK + 4]), 64'd1);
    step();

    for (int i = 0; i < 6; i++) begin
      idle(); write = 1'b1; wr_adr = BITADDR'(100 + i); bw = '1; din = 32'hA000_0000 + i; step();
    end
    for (int i = 0; i < 6; i++) begin
      idle(); read[3] = 1'b1; rd_adr[3*BITADDR +: BITADDR] = BITADDR'(100 + i); step();
    end
    idle(); repeat (6) step();

    for (int i = 0; i < 1500; i++) begin rnd_stim(); step(); end

    // Reset with a read in flight: it must never return.
    idle(); read[0] = 1'b1; rd_adr[BITADDR-1:0] = 13'd9; step();
    idle(); rst = 1'b1; repeat (5) step();
    rst = 1'b0;
    for (int i = 0; i < int'(NUMVROW) + 1; i++) begin rnd_stim(); step(); end
    idle(); rd_all(13'd9); step(); idle(); repeat (4) step();
    for (int i = 0; i < 300; i++) begin rnd_stim(); step(); end
    idle(); repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
